// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module : y86_pkg
// Brief  : Shared Y86 status, icode, register and control-FSM definitions
// Rev    : 1.0
// ============================================================================
package y86_pkg;

    localparam logic [1:0] c_STAT_AOK = 2'd0;
    localparam logic [1:0] c_STAT_HLT = 2'd1;
    localparam logic [1:0] c_STAT_ADR = 2'd2;
    localparam logic [1:0] c_STAT_INS = 2'd3;

    localparam logic [3:0] c_ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] c_ICODE_JXX    = 4'h7;
    localparam logic [3:0] c_ICODE_RET    = 4'h9;
    localparam logic [3:0] c_ICODE_POPQ   = 4'hB;

    localparam logic [3:0] c_RNONE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } ctrl_state_t;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module : hazard_detect
// Brief  : Combinational load-use, return-pending and mispredict detection
// Rev    : 1.0
// ============================================================================
module hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] E_icode,
    input  logic [3:0] M_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    output logic       loaduse,
    output logic       retpend,
    output logic       mispred
);

    logic w_e_is_load;
    logic w_dst_match;

    assign w_e_is_load = (E_icode == c_ICODE_MRMOVQ) || (E_icode == c_ICODE_POPQ);
    assign w_dst_match = (E_dstM != c_RNONE) && ((E_dstM == d_srcA) || (E_dstM == d_srcB));

    assign loaduse = w_e_is_load && w_dst_match;
    assign retpend = (D_icode == c_ICODE_RET) || (E_icode == c_ICODE_RET)
                  || (M_icode == c_ICODE_RET);
    assign mispred = (E_icode == c_ICODE_JXX) && !e_Cnd;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe_ctrl
// Brief  : Y86 pipeline control: run/drain/halt FSM, stall/bubble steering
//          and saturating performance counters
// Rev    : 1.0
// ============================================================================
module pipe_ctrl
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic [3:0]  E_dstM,
    input  logic        e_Cnd,
    input  logic [1:0]  m_stat,
    input  logic [1:0]  W_stat,
    output logic        F_stall,
    output logic        D_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        M_bubble,
    output logic        W_stall,
    output logic        halted,
    output logic [1:0]  cpu_stat,
    output logic [31:0] cyc_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] mispred_cnt
);

    logic        w_loaduse;
    logic        w_retpend;
    logic        w_mispred;
    logic        w_m_bad;
    logic        w_w_bad;
    logic        w_in_run;
    logic        w_in_drain;

    ctrl_state_t r_state;
    logic        r_halted;
    logic [1:0]  r_cpu_stat;
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_mispred_cnt;

    hazard_detect u_hazard_detect (
        .D_icode (D_icode),
        .E_icode (E_icode),
        .M_icode (M_icode),
        .d_srcA  (d_srcA),
        .d_srcB  (d_srcB),
        .E_dstM  (E_dstM),
        .e_Cnd   (e_Cnd),
        .loaduse (w_loaduse),
        .retpend (w_retpend),
        .mispred (w_mispred)
    );

    assign w_m_bad    = (m_stat != c_STAT_AOK);
    assign w_w_bad    = (W_stat != c_STAT_AOK);
    assign w_in_run   = (r_state == ST_RUN);
    assign w_in_drain = (r_state == ST_DRAIN);

    // A faulting writeback always wins: it halts from RUN without a drain phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_halted   <= 1'b0;
            r_cpu_stat <= c_STAT_AOK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_w_bad) begin
                        r_state    <= ST_HALTED;
                        r_halted   <= 1'b1;
                        r_cpu_stat <= W_stat;
                    end else if (w_m_bad) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_w_bad) begin
                        r_state    <= ST_HALTED;
                        r_halted   <= 1'b1;
                        r_cpu_stat <= W_stat;
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_cnt     <= 32'd0;
            r_stall_cnt   <= 32'd0;
            r_mispred_cnt <= 32'd0;
        end else begin
            if (w_in_run || w_in_drain) begin
                r_cyc_cnt <= sat_inc(r_cyc_cnt);
            end
            if (w_in_run && (w_loaduse || w_retpend)) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (w_in_run && w_mispred) begin
                r_mispred_cnt <= sat_inc(r_mispred_cnt);
            end
        end
    end

    // Defaults are the frozen-pipeline pattern used in IDLE and HALTED.
    always_comb begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
        case (r_state)
            ST_RUN: begin
                F_stall  = w_loaduse | w_retpend;
                D_stall  = w_loaduse;
                D_bubble = w_mispred | (w_retpend & ~w_loaduse);
                E_bubble = w_mispred | w_loaduse;
                M_bubble = w_m_bad | w_w_bad;
                W_stall  = w_w_bad;
            end
            ST_DRAIN: begin
                F_stall  = 1'b1;
                D_stall  = 1'b0;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = w_w_bad;
            end
            default: begin
            end
        endcase
    end

    assign halted      = r_halted;
    assign cpu_stat    = r_cpu_stat;
    assign cyc_cnt     = r_cyc_cnt;
    assign stall_cnt   = r_stall_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_ctrl
// Brief  : Scoreboard bench for pipe_ctrl with directed hazard/halt vectors
// Rev    : 1.0
// ============================================================================
module tb_pipe_ctrl;
    import y86_pkg::*;

    // Control vector order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
    localparam logic [5:0] c_CTRL_FROZEN  = 6'b110111;
    localparam logic [5:0] c_CTRL_NONE    = 6'b000000;
    localparam logic [5:0] c_CTRL_LOADUSE = 6'b110100;
    localparam logic [5:0] c_CTRL_MISPRED = 6'b001100;
    localparam logic [5:0] c_CTRL_RET     = 6'b101000;
    localparam logic [5:0] c_CTRL_RETMIS  = 6'b101100;
    localparam logic [5:0] c_CTRL_MBAD    = 6'b000010;
    localparam logic [5:0] c_CTRL_WBAD    = 6'b000011;
    localparam logic [5:0] c_CTRL_DRAIN   = 6'b101110;
    localparam logic [5:0] c_CTRL_DRAINW  = 6'b101111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  D_icode, E_icode, M_icode;
    logic [3:0]  d_srcA, d_srcB, E_dstM;
    logic        e_Cnd;
    logic [1:0]  m_stat, W_stat;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic        halted;
    logic [1:0]  cpu_stat;
    logic [31:0] cyc_cnt, stall_cnt, mispred_cnt;
    logic [5:0]  ctrl_obs;

    typedef struct {
        string       name;
        logic [5:0]  ctrl;
        logic        halted;
        logic [1:0]  cpu_stat;
        logic [31:0] cyc;
        logic [31:0] stall;
        logic [31:0] misp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .D_icode     (D_icode),
        .E_icode     (E_icode),
        .M_icode     (M_icode),
        .d_srcA      (d_srcA),
        .d_srcB      (d_srcB),
        .E_dstM      (E_dstM),
        .e_Cnd       (e_Cnd),
        .m_stat      (m_stat),
        .W_stat      (W_stat),
        .F_stall     (F_stall),
        .D_stall     (D_stall),
        .D_bubble    (D_bubble),
        .E_bubble    (E_bubble),
        .M_bubble    (M_bubble),
        .W_stall     (W_stall),
        .halted      (halted),
        .cpu_stat    (cpu_stat),
        .cyc_cnt     (cyc_cnt),
        .stall_cnt   (stall_cnt),
        .mispred_cnt (mispred_cnt)
    );

    assign ctrl_obs = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};

    task automatic check(input string nm, input string fld,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: every pushed expectation is compared at the following negedge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, "ctrl",        32'(ctrl_obs),  32'(e.ctrl));
            check(e.name, "halted",      32'(halted),    32'(e.halted));
            check(e.name, "cpu_stat",    32'(cpu_stat),  32'(e.cpu_stat));
            check(e.name, "cyc_cnt",     cyc_cnt,        e.cyc);
            check(e.name, "stall_cnt",   stall_cnt,      e.stall);
            check(e.name, "mispred_cnt", mispred_cnt,    e.misp);
        end
    end

    task automatic clear_inputs();
        start   = 1'b0;
        D_icode = 4'h0;
        E_icode = 4'h0;
        M_icode = 4'h0;
        d_srcA  = c_RNONE;
        d_srcB  = c_RNONE;
        E_dstM  = c_RNONE;
        e_Cnd   = 1'b1;
        m_stat  = c_STAT_AOK;
        W_stat  = c_STAT_AOK;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic expect_cycle(input string nm, input logic [5:0] ctrl, input logic h,
                                input logic [1:0] cs, input logic [31:0] cyc,
                                input logic [31:0] st, input logic [31:0] mp);
        exp_t e;
        e.name = nm; e.ctrl = ctrl; e.halted = h; e.cpu_stat = cs;
        e.cyc = cyc; e.stall = st; e.misp = mp;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();

        // Reset, idle, start, then hazard-free run
        next_cycle(); expect_cycle("reset", c_CTRL_FROZEN, 0, 0, 0, 0, 0);
        next_cycle(); rst_n = 1'b1; expect_cycle("idle", c_CTRL_FROZEN, 0, 0, 0, 0, 0);
        next_cycle(); start = 1'b1; expect_cycle("idle_start", c_CTRL_FROZEN, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); expect_cycle("run_nohaz", c_CTRL_NONE, 0, 0, 32'(i), 0, 0);
        end

        // Load-use
        next_cycle(); E_icode = c_ICODE_MRMOVQ; E_dstM = 4'h3; d_srcB = 4'h3;
        expect_cycle("loaduse", c_CTRL_LOADUSE, 0, 0, 4, 0, 0);
        next_cycle(); E_icode = c_ICODE_MRMOVQ; E_dstM = c_RNONE; d_srcB = 4'h3;
        expect_cycle("ld_rnone", c_CTRL_NONE, 0, 0, 5, 1, 0);
        next_cycle(); E_icode = c_ICODE_POPQ; E_dstM = 4'h4; d_srcA = 4'h4;
        expect_cycle("popq_lu", c_CTRL_LOADUSE, 0, 0, 6, 1, 0);

        // Branch mispredict
        next_cycle(); E_icode = c_ICODE_JXX; e_Cnd = 1'b0;
        expect_cycle("mispred", c_CTRL_MISPRED, 0, 0, 7, 2, 0);
        next_cycle(); E_icode = c_ICODE_JXX; e_Cnd = 1'b1;
        expect_cycle("jxx_taken", c_CTRL_NONE, 0, 0, 8, 2, 1);

        // Return walking through D, E, M and combinations
        next_cycle(); D_icode = c_ICODE_RET;
        expect_cycle("ret_d", c_CTRL_RET, 0, 0, 9, 2, 1);
        next_cycle(); E_icode = c_ICODE_RET;
        expect_cycle("ret_e", c_CTRL_RET, 0, 0, 10, 3, 1);
        next_cycle(); M_icode = c_ICODE_RET;
        expect_cycle("ret_m", c_CTRL_RET, 0, 0, 11, 4, 1);
        next_cycle(); D_icode = c_ICODE_RET; E_icode = c_ICODE_MRMOVQ; E_dstM = 4'h2; d_srcA = 4'h2;
        expect_cycle("ret_lu", c_CTRL_LOADUSE, 0, 0, 12, 5, 1);
        next_cycle(); D_icode = c_ICODE_RET; E_icode = c_ICODE_JXX; e_Cnd = 1'b0;
        expect_cycle("ret_mis", c_CTRL_RETMIS, 0, 0, 13, 6, 1);

        // Memory fault -> drain -> halt
        next_cycle(); m_stat = c_STAT_ADR;
        expect_cycle("m_adr", c_CTRL_MBAD, 0, 0, 14, 7, 2);
        next_cycle(); expect_cycle("drain", c_CTRL_DRAIN, 0, 0, 15, 7, 2);
        next_cycle(); W_stat = c_STAT_ADR;
        expect_cycle("drain_w", c_CTRL_DRAINW, 0, 0, 16, 7, 2);
        next_cycle(); start = 1'b1;
        expect_cycle("halt_start", c_CTRL_FROZEN, 1, c_STAT_ADR, 17, 7, 2);
        next_cycle(); E_icode = c_ICODE_MRMOVQ; E_dstM = 4'h1; d_srcA = 4'h1;
        expect_cycle("halt_lu", c_CTRL_FROZEN, 1, c_STAT_ADR, 17, 7, 2);
        next_cycle(); expect_cycle("halt_hold", c_CTRL_FROZEN, 1, c_STAT_ADR, 17, 7, 2);

        // Writeback fault halts straight from RUN
        next_cycle(); rst_n = 1'b0; expect_cycle("rst2", c_CTRL_FROZEN, 0, 0, 0, 0, 0);
        next_cycle(); rst_n = 1'b1; expect_cycle("idle2", c_CTRL_FROZEN, 0, 0, 0, 0, 0);
        next_cycle(); start = 1'b1; expect_cycle("start2", c_CTRL_FROZEN, 0, 0, 0, 0, 0);
        next_cycle(); W_stat = c_STAT_INS;
        expect_cycle("run_wins", c_CTRL_WBAD, 0, 0, 0, 0, 0);
        next_cycle(); expect_cycle("halt_ins", c_CTRL_FROZEN, 1, c_STAT_INS, 1, 0, 0);

        // Counter saturation, then asynchronous reset in the middle of a drain
        next_cycle(); rst_n = 1'b0; expect_cycle("rst3", c_CTRL_FROZEN, 0, 0, 0, 0, 0);
        next_cycle(); rst_n = 1'b1; expect_cycle("idle3", c_CTRL_FROZEN, 0, 0, 0, 0, 0);
        next_cycle(); start = 1'b1; expect_cycle("start3", c_CTRL_FROZEN, 0, 0, 0, 0, 0);
        next_cycle(); expect_cycle("run3", c_CTRL_NONE, 0, 0, 0, 0, 0);
        next_cycle();
        force dut.r_cyc_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_cyc_cnt;
        expect_cycle("preload", c_CTRL_NONE, 0, 0, 32'hFFFF_FFFE, 0, 0);
        next_cycle(); expect_cycle("sat_hit", c_CTRL_NONE, 0, 0, 32'hFFFF_FFFF, 0, 0);
        next_cycle(); expect_cycle("sat_hold", c_CTRL_NONE, 0, 0, 32'hFFFF_FFFF, 0, 0);
        next_cycle(); m_stat = c_STAT_HLT;
        expect_cycle("m_hlt", c_CTRL_MBAD, 0, 0, 32'hFFFF_FFFF, 0, 0);
        next_cycle(); expect_cycle("drain3", c_CTRL_DRAIN, 0, 0, 32'hFFFF_FFFF, 0, 0);
        next_cycle(); W_stat = c_STAT_HLT; rst_n = 1'b0;
        expect_cycle("rst_drain", c_CTRL_FROZEN, 0, 0, 0, 0, 0);
        next_cycle(); rst_n = 1'b1; expect_cycle("after_rst", c_CTRL_FROZEN, 0, 0, 0, 0, 0);
        next_cycle(); expect_cycle("still_idle", c_CTRL_FROZEN, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        check("end", "sb_left", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: start  in  1  one-cycle pulse; leaves IDLE.
REQ-004 SHALL have ports: D_icode, E_icode, M_icode  in  4 each  icodes in the decode, execute and memory registers.
REQ-005 SHALL have ports: d_srcA, d_srcB  in  4 each  decode source register IDs.
REQ-006 SHALL have ports: E_dstM  in  4  execute-stage load destination.
REQ-007 SHALL have ports: e_Cnd  in  1  branch condition from execute.
REQ-008 SHALL have ports: m_stat, W_stat  in  2 each  memory-stage and writeback-stage status.
REQ-009 SHALL have ports: F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  out  1 each  pipeline-register controls.
REQ-010 SHALL have ports: halted  out  1  HALTED state; cpu_stat  out  2  latched final status.
REQ-011 SHALL have ports: cyc_cnt, stall_cnt, mispred_cnt  out  32 each  performance counters.

Function
REQ-012 SHALL use encodings: stat AOK=0, HLT=1, ADR=2, INS=3; icode MRMOVQ=5, JXX=7, RET=9, POPQ=B; RNONE=F.
REQ-013 SHALL implement FSM IDLE -> RUN on start; RUN -> DRAIN when m_stat!=AOK; DRAIN -> HALTED when W_stat!=AOK; HALTED is terminal until reset.
REQ-014 SHALL take RUN -> HALTED directly when W_stat!=AOK in RUN; start outside IDLE SHALL be ignored.
REQ-015 SHALL define loaduse = E_icode in {MRMOVQ,POPQ} and E_dstM!=RNONE and E_dstM in {d_srcA,d_srcB}.
REQ-016 SHALL define retpend = RET in {D_icode,E_icode,M_icode} and mispred = E_icode==JXX and !e_Cnd.
REQ-017 SHALL, in RUN, drive combinationally F_stall=loaduse|retpend, D_stall=loaduse, D_bubble=mispred|(retpend&!loaduse), E_bubble=mispred|loaduse, M_bubble=(m_stat!=AOK)|(W_stat!=AOK), W_stall=(W_stat!=AOK).
REQ-018 SHALL, with loaduse and retpend together, give D_stall priority: D_bubble=0 unless mispred.
REQ-019 SHALL, in DRAIN, drive F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1, D_stall=0, W_stall=(W_stat!=AOK).
REQ-020 SHALL, in IDLE and HALTED, drive F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0.
REQ-021 SHALL latch cpu_stat<=W_stat on the cycle entering HALTED and hold it there.
REQ-022 SHALL assert halted only while in HALTED.
REQ-023 SHALL increment cyc_cnt each cycle in RUN or DRAIN.
REQ-024 SHALL increment stall_cnt each RUN cycle with loaduse|retpend.
REQ-025 SHALL increment mispred_cnt each RUN cycle with mispred.
REQ-026 SHALL saturate all counters at 0xFFFFFFFF; they SHALL not wrap.

Reset
REQ-027 SHALL, on rst_n low, asynchronously enter IDLE and clear cpu_stat (to AOK) and all counters; control outputs SHALL take their IDLE values.
REQ-028 SHALL, if reset is asserted mid-RUN or mid-DRAIN, abandon the state immediately, with no drain completion.

Structure
REQ-029 SHALL take stat, icode, RNONE and FSM-state constants from a shared package y86_pkg, which the stage registers also use.
REQ-030 SHALL contain one sub-module, hazard_detect, that is combinational and produces loaduse/retpend/mispred; the FSM, output muxing and counters SHALL stay in pipe_ctrl.

Verification
REQ-031 SHALL cover this scenario: reset, then start pulse -> IDLE outputs before the pulse; RUN next cycle, all controls 0 with no hazards; cyc_cnt counts 1,2,3.
REQ-032 SHALL cover this scenario: E_icode=5, E_dstM=3, d_srcB=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0; stall_cnt +1; with E_dstM=F, no stall.
REQ-033 SHALL cover this scenario: E_icode=7, e_Cnd=0 -> D_bubble=E_bubble=1, F_stall=0; mispred_cnt +1; with e_Cnd=1, nothing is asserted.
REQ-034 SHALL cover this scenario: D_icode=9 for one cycle, then E_icode=9, then M_icode=9 -> F_stall=1 and D_bubble=1 each cycle; combined with loaduse -> D_stall=1, D_bubble=0.
REQ-035 SHALL cover this scenario: m_stat=ADR in RUN -> DRAIN; next cycle W_stat=ADR -> HALTED, cpu_stat=2, halted=1; cyc_cnt frozen; a later start is ignored.
REQ-036 SHALL cover this scenario: rst_n low mid-DRAIN -> asynchronous return to IDLE with counters 0; cyc_cnt preloaded to 0xFFFFFFFE saturates at 0xFFFFFFFF.
